// File: rtl/heartbeat_ctrl.sv
// heartbeat_ctrl
//   Wishbone-classic slave that sequences an 8-bit heartbeat counter.
//   A programmable prescaler generates ticks every PERIOD+1 clocks while the
//   sequencer is running. The sequencer runs either free (until EN drops) or
//   for a counted burst of BURST ticks, then raises a sticky DONE flag that
//   can drive a maskable level interrupt.
//
// Ports
//   wb_clk_i   : clock, all logic on the rising edge
//   wb_rst_i   : synchronous active-high reset
//   wbs_stb_i  : Wishbone strobe
//   wbs_cyc_i  : Wishbone cycle
//   wbs_we_i   : write enable
//   wbs_sel_i  : byte enables
//   wbs_dat_i  : write data
//   wbs_adr_i  : byte address (window decoded on [31:4], register on [3:2])
//   wbs_ack_o  : one-cycle acknowledge
//   wbs_dat_o  : registered read data, zero outside of ack
//   hb_out     : heartbeat output, hb_count[7]
//   hb_count   : current heartbeat count
//   irq        : registered level interrupt, DONE & IRQ_EN
//
// Register map (adr[3:2])
//   0 CTRL   : [0] EN, [1] MODE (1 = burst), [2] START (write-1 pulse), [3] IRQ_EN
//   1 PERIOD : [PERIOD_W-1:0] prescaler terminal value
//   2 BURST  : [7:0] ticks per burst
//   3 STATUS : [0] BUSY, [1] DONE (W1C), [15:8] hb_count, [23:16] remaining

module heartbeat_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned PERIOD_W  = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        hb_out,
    output logic [7:0]  hb_count,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q;

    logic                ack_q;
    logic [31:0]         dat_q;
    logic [31:0]         dat_d;

    logic                en_q;
    logic                en_d;
    logic                mode_q;
    logic                mode_d;
    logic                irq_en_q;
    logic                irq_en_d;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_d;
    logic [7:0]          burst_q;
    logic [7:0]          burst_d;

    logic [PERIOD_W-1:0] presc_q;
    logic [7:0]          hb_count_q;
    logic [7:0]          remaining_q;
    logic                burst_mode_q;
    logic                done_q;
    logic                irq_q;

    logic                sel_w;
    logic                access;
    logic                wr;
    logic                rd;
    logic                wr_ctrl;
    logic                wr_period;
    logic                wr_burst;
    logic                wr_status;
    logic                start;
    logic                clr_done;
    logic                tick;
    logic [31:0]         period_ext;
    logic [31:0]         period_wr;
    logic [31:0]         rdata;
    logic                unused_bits;

    // ------------------------------------------------------------------
    // Bus decode and register next-state
    // ------------------------------------------------------------------
    always_comb begin
        sel_w     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        // The request is serviced on the edge that raises ack; a held strobe
        // therefore gets one access every other cycle.
        access    = sel_w && !ack_q;
        wr        = access && wbs_we_i;
        rd        = access && !wbs_we_i;
        wr_ctrl   = wr && (wbs_adr_i[3:2] == 2'd0);
        wr_period = wr && (wbs_adr_i[3:2] == 2'd1);
        wr_burst  = wr && (wbs_adr_i[3:2] == 2'd2);
        wr_status = wr && (wbs_adr_i[3:2] == 2'd3);

        en_d     = en_q;
        mode_d   = mode_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl && wbs_sel_i[0]) begin
            en_d     = wbs_dat_i[0];
            mode_d   = wbs_dat_i[1];
            irq_en_d = wbs_dat_i[3];
        end
        start    = wr_ctrl && wbs_sel_i[0] && wbs_dat_i[2];
        clr_done = wr_status && wbs_sel_i[0] && wbs_dat_i[1];

        period_ext = 32'(period_q);
        period_wr  = period_ext;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                period_wr[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end
        end
        period_d = wr_period ? period_wr[PERIOD_W-1:0] : period_q;

        burst_d = (wr_burst && wbs_sel_i[0]) ? wbs_dat_i[7:0] : burst_q;

        case (wbs_adr_i[3:2])
            2'd0:    rdata = {28'd0, irq_en_q, 1'b0, mode_q, en_q};
            2'd1:    rdata = period_ext;
            2'd2:    rdata = {24'd0, burst_q};
            default: rdata = {8'd0, remaining_q, hb_count_q, 6'd0, done_q,
                              (state_q == S_RUN)};
        endcase
        dat_d = rd ? rdata : '0;

        // >= rather than == so a PERIOD lowered below the running count
        // ticks immediately instead of waiting for a full wrap.
        tick = (state_q == S_RUN) && en_q && (presc_q >= period_q);

        unused_bits = ^{wbs_adr_i[1:0], period_wr};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            period_q <= '0;
            burst_q  <= '0;
        end else begin
            ack_q    <= access;
            dat_q    <= dat_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            period_q <= period_d;
            burst_q  <= burst_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            hb_count_q   <= '0;
            remaining_q  <= '0;
            burst_mode_q <= 1'b0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            irq_q <= done_q && irq_en_q;
            if (clr_done) begin
                done_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    presc_q <= '0;
                    // START uses the CTRL value being written alongside it.
                    if (start && en_d && mode_d) begin
                        remaining_q  <= burst_q;
                        burst_mode_q <= 1'b1;
                        state_q      <= (burst_q == 8'd0) ? S_DONE : S_RUN;
                    end else if (en_q && !mode_q) begin
                        burst_mode_q <= 1'b0;
                        state_q      <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (!en_q) begin
                        presc_q <= '0;
                        state_q <= S_IDLE;
                    end else if (tick) begin
                        presc_q    <= '0;
                        hb_count_q <= hb_count_q + 8'd1;
                        // The mode latched at entry governs the whole run.
                        if (burst_mode_q) begin
                            remaining_q <= remaining_q - 8'd1;
                            if (remaining_q <= 8'd1) begin
                                state_q <= S_DONE;
                            end
                        end
                    end else begin
                        presc_q <= presc_q + PERIOD_W'(1);
                    end
                end

                S_DONE: begin
                    presc_q <= '0;
                    state_q <= S_IDLE;
                    // Set overrides a same-cycle W1C; an abort via EN=0
                    // does not report completion.
                    if (en_q) begin
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    presc_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign hb_count  = hb_count_q;
    assign hb_out    = hb_count_q[7];
    assign irq       = irq_q;

endmodule

// File: tb/tb_heartbeat_ctrl.sv
module tb_heartbeat_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [3:0]  R_CTRL   = 4'h0;
    localparam logic [3:0]  R_PERIOD = 4'h4;
    localparam logic [3:0]  R_BURST  = 4'h8;
    localparam logic [3:0]  R_STATUS = 4'hC;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        hb_out;
    logic [7:0]  hb_count;
    logic        irq;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   nvec;
    int   nerr;

    heartbeat_ctrl #(
        .BASE_ADDR (BASE),
        .PERIOD_W  (24)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .hb_out    (hb_out),
        .hb_count  (hb_count),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry; reads compare data.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected ack: got ack with dat %h, expected no ack", dat_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_rd) check(e.name, dat_o, e.data);
            end
        end
    end

    task automatic xfer(input bit w, input logic [3:0] off, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp, input string name);
        @(negedge clk);
        stb   = 1'b1;
        cyc   = 1'b1;
        we    = w;
        adr   = BASE | {28'd0, off};
        sel   = s;
        dat_i = d;
        exp_q.push_back('{!w, exp, name});
        @(posedge clk); #1;
        check({name, " ack latency"}, {31'd0, ack}, 32'd1);
        @(negedge clk);
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        @(posedge clk); #1;
        check({name, " ack width"}, {31'd0, ack}, 32'd0);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input string name);
        xfer(1'b1, off, d, 4'hF, 32'd0, name);
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string name);
        xfer(1'b0, off, 32'd0, 4'hF, exp, name);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_hb(input string name, input logic [7:0] exp);
        check(name, {24'd0, hb_count}, {24'd0, exp});
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; dat_i = 32'd0; adr = 32'd0;

        // ---------------- reset state and register reads
        do_reset();
        #1;
        check("reset hb_count", {24'd0, hb_count}, 32'd0);
        check("reset hb_out", {31'd0, hb_out}, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);
        check("reset ack", {31'd0, ack}, 32'd0);
        check("reset dat_o", dat_o, 32'd0);
        rd(R_CTRL,   32'd0, "rst CTRL");
        rd(R_PERIOD, 32'd0, "rst PERIOD");
        rd(R_BURST,  32'd0, "rst BURST");
        rd(R_STATUS, 32'd0, "rst STATUS");

        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10;
        repeat (4) begin
            @(posedge clk); #1;
            check("out-of-window ack", {31'd0, ack}, 32'd0);
        end
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0;

        // ---------------- free-run, PERIOD=0: one tick per clock
        wr(R_CTRL, 32'h1, "free CTRL");
        chk_hb("free entry", 8'd0);
        for (int k = 1; k <= 256; k++) begin
            logic [8:0] e;
            e = {k[7], k[7:0]};
            @(posedge clk); #1;
            check("free hb_out/count", {23'd0, hb_out, hb_count}, {23'd0, e});
        end
        wr(R_CTRL, 32'h0, "free stop");
        rd(R_STATUS, 32'h0000_0100, "free STATUS");

        // ---------------- burst of 5, PERIOD=3
        do_reset();
        wr(R_PERIOD, 32'd3, "b5 PERIOD");
        wr(R_BURST,  32'd5, "b5 BURST");
        wr(R_CTRL,   32'hB, "b5 CTRL");
        wr(R_CTRL,   32'hF, "b5 START");
        for (int k = 1; k <= 22; k++) begin
            int t;
            t = (k + 1) / 4;
            if (t > 5) t = 5;
            @(posedge clk); #1;
            check("b5 hb_count", {24'd0, hb_count}, t);
            check("b5 irq", {31'd0, irq}, (k >= 21) ? 32'd1 : 32'd0);
        end
        rd(R_STATUS, 32'h0000_0502, "b5 STATUS");
        wr(R_STATUS, 32'h2, "b5 W1C");
        check("b5 irq cleared", {31'd0, irq}, 32'd0);

        // ---------------- BURST=0: straight to DONE
        wr(R_BURST, 32'd0, "b0 BURST");
        wr(R_CTRL,  32'hF, "b0 START");
        rd(R_STATUS, 32'h0000_0502, "b0 STATUS");
        wr(R_STATUS, 32'h2, "b0 W1C");

        // ---------------- burst of 10 with a START while busy
        wr(R_BURST, 32'd10, "b10 BURST");
        wr(R_CTRL,  32'hF,  "b10 START");
        wr(R_CTRL,  32'hF,  "b10 START busy");
        rd(R_STATUS, 32'h000A_0501, "b10 STATUS busy");
        repeat (34) @(posedge clk);
        #1;
        chk_hb("b10 before last", 8'd14);
        @(posedge clk); #1;
        chk_hb("b10 last tick", 8'd15);
        repeat (5) @(posedge clk);
        rd(R_STATUS, 32'h0000_0F02, "b10 STATUS done");

        // ---------------- DONE set and W1C in the same cycle
        wr(R_STATUS, 32'h2, "b1 pre W1C");
        wr(R_BURST,  32'd1, "b1 BURST");
        wr(R_PERIOD, 32'd0, "b1 PERIOD");
        wr(R_CTRL,   32'hF, "b1 START");
        wr(R_STATUS, 32'h2, "b1 racing W1C");
        rd(R_STATUS, 32'h0000_1002, "b1 set wins");
        wr(R_STATUS, 32'h2, "b1 W1C");
        rd(R_STATUS, 32'h0000_1000, "b1 cleared");

        // ---------------- PERIOD lowered below running prescaler
        wr(R_PERIOD, 32'd100, "p PERIOD 100");
        wr(R_CTRL,   32'h1,   "p CTRL");
        chk_hb("p entry", 8'h10);
        repeat (49) @(posedge clk);
        wr(R_PERIOD, 32'd10, "p PERIOD 10");
        chk_hb("p tick after shrink", 8'h11);
        wr(R_CTRL, 32'h0, "p EN off");
        chk_hb("p after EN off", 8'h11);
        rd(R_STATUS, 32'h0000_1100, "p STATUS idle");
        repeat (30) @(posedge clk);
        #1;
        chk_hb("p frozen", 8'h11);

        // ---------------- byte-lane gating
        xfer(1'b1, R_PERIOD, 32'hFFFF_FFFF, 4'b0001, 32'd0, "lane PERIOD");
        rd(R_PERIOD, 32'h0000_00FF, "lane PERIOD rb");

        // ---------------- reset mid-burst with a read in flight
        wr(R_PERIOD, 32'd3,   "r PERIOD");
        wr(R_BURST,  32'hFF,  "r BURST");
        wr(R_CTRL,   32'hF,   "r START");
        repeat (20) @(posedge clk);
        #1;
        chk_hb("r mid-burst", 8'h16);
        @(negedge clk);
        rst = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE;
        @(posedge clk); #1;
        check("r hb_count", {24'd0, hb_count}, 32'd0);
        check("r hb_out", {31'd0, hb_out}, 32'd0);
        check("r irq", {31'd0, irq}, 32'd0);
        check("r ack dropped", {31'd0, ack}, 32'd0);
        check("r dat_o", dat_o, 32'd0);
        @(negedge clk);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0;
        rd(R_CTRL,   32'd0, "r CTRL");
        rd(R_PERIOD, 32'd0, "r PERIOD rb");
        rd(R_BURST,  32'd0, "r BURST rb");
        rd(R_STATUS, 32'd0, "r STATUS");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
